// File: rtl/hazard_scoreboard_pkg.sv
// Shared forwarding-select codes and decode timing constants for the hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_GRF = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  // Tuse value meaning "operand not read by this instruction".
  localparam logic [1:0] TUSE_NONE = 2'd3;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// One source operand compared against the E/M/W pending-write entries.
// Produces that operand's stall request and its forward select.
module hazard_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW = 5,
  parameter int TW = 2
) (
  input  logic [AW-1:0] src,
  input  logic [TW-1:0] tuse,
  input  logic          e_vld,
  input  logic [AW-1:0] e_a3,
  input  logic [TW-1:0] e_tnew,
  input  logic          m_vld,
  input  logic [AW-1:0] m_a3,
  input  logic [TW-1:0] m_tnew,
  input  logic          w_vld,
  input  logic [AW-1:0] w_a3,
  input  logic [TW-1:0] w_tnew,
  output logic          need_stall,
  output logic [1:0]    sel
);

  logic hit_e, hit_m, hit_w;

  assign hit_e = e_vld && (e_a3 == src) && (src != '0);
  assign hit_m = m_vld && (m_a3 == src) && (src != '0);
  assign hit_w = w_vld && (w_a3 == src) && (src != '0);

  assign need_stall = (hit_e && (e_tnew > tuse)) || (hit_m && (m_tnew > tuse));

  // The youngest hit decides; if it is not ready yet, older stages must not forward stale data.
  always_comb begin
    sel = FWD_GRF;
    if (hit_e) begin
      sel = (e_tnew == '0) ? FWD_E : FWD_GRF;
    end else if (hit_m) begin
      sel = (m_tnew == '0) ? FWD_M : FWD_GRF;
    end else if (hit_w) begin
      sel = (w_tnew == '0) ? FWD_W : FWD_GRF;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pending-GPR-write scoreboard beside D: stall request and per-operand forward selects.
// HAZARD_STAT_EN adds a free-running stall-cycle counter output.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW = 5,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [AW-1:0] d_a3,
  input  logic [TW-1:0] d_tnew,
  output logic          stall,
  output logic [1:0]    fwd_rs_sel,
  output logic [1:0]    fwd_rt_sel
`ifdef HAZARD_STAT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  logic          e_vld, m_vld, w_vld;
  logic [AW-1:0] e_a3, m_a3, w_a3;
  logic [TW-1:0] e_tnew, m_tnew, w_tnew;
  logic          rs_stall, rt_stall;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // On stall the D instruction stays put, so a bubble enters E.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_vld  <= 1'b0;
      e_a3   <= '0;
      e_tnew <= '0;
      m_vld  <= 1'b0;
      m_a3   <= '0;
      m_tnew <= '0;
      w_vld  <= 1'b0;
      w_a3   <= '0;
      w_tnew <= '0;
    end else begin
      if (stall) begin
        e_vld  <= 1'b0;
        e_a3   <= '0;
        e_tnew <= '0;
      end else begin
        e_vld  <= (d_a3 != '0);
        e_a3   <= d_a3;
        e_tnew <= d_tnew;
      end
      m_vld  <= e_vld;
      m_a3   <= e_a3;
      m_tnew <= sat_dec(e_tnew);
      w_vld  <= m_vld;
      w_a3   <= m_a3;
      w_tnew <= sat_dec(m_tnew);
    end
  end

  hazard_match #(.AW(AW), .TW(TW)) u_match_rs (
    .src        (d_rs),
    .tuse       (d_tuse_rs),
    .e_vld      (e_vld),
    .e_a3       (e_a3),
    .e_tnew     (e_tnew),
    .m_vld      (m_vld),
    .m_a3       (m_a3),
    .m_tnew     (m_tnew),
    .w_vld      (w_vld),
    .w_a3       (w_a3),
    .w_tnew     (w_tnew),
    .need_stall (rs_stall),
    .sel        (fwd_rs_sel)
  );

  hazard_match #(.AW(AW), .TW(TW)) u_match_rt (
    .src        (d_rt),
    .tuse       (d_tuse_rt),
    .e_vld      (e_vld),
    .e_a3       (e_a3),
    .e_tnew     (e_tnew),
    .m_vld      (m_vld),
    .m_a3       (m_a3),
    .m_tnew     (m_tnew),
    .w_vld      (w_vld),
    .w_a3       (w_a3),
    .w_tnew     (w_tnew),
    .need_stall (rt_stall),
    .sel        (fwd_rt_sel)
  );

  assign stall = rs_stall || rt_stall;

`ifdef HAZARD_STAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard; expected values are hand-derived per scenario.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic       clk;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       stall;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;
`ifdef HAZARD_STAT_EN
  logic [31:0] stall_cnt;
`endif

  int n_vec;
  int n_bad;

  hazard_scoreboard #(.AW(5), .TW(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .d_rs       (d_rs),
    .d_rt       (d_rt),
    .d_tuse_rs  (d_tuse_rs),
    .d_tuse_rt  (d_tuse_rt),
    .d_a3       (d_a3),
    .d_tnew     (d_tnew),
    .stall      (stall),
    .fwd_rs_sel (fwd_rs_sel),
    .fwd_rt_sel (fwd_rt_sel)
`ifdef HAZARD_STAT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic [1:0] trt,
                       input logic [4:0] a3, input logic [1:0] tnew);
    d_rs = rs; d_tuse_rs = trs;
    d_rt = rt; d_tuse_rt = trt;
    d_a3 = a3; d_tnew = tnew;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
  endtask

  task automatic chk_out(input string tag, input logic s, input logic [1:0] rs_sel, input logic [1:0] rt_sel);
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, s});
    chk({tag, ".rs_sel"}, {30'd0, fwd_rs_sel}, {30'd0, rs_sel});
    chk({tag, ".rt_sel"}, {30'd0, fwd_rt_sel}, {30'd0, rt_sel});
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 2'd0);
    #12;
    // Reset state with a D instruction that would hit if any entry were valid.
    set_d(5'd1, 2'd0, 5'd2, 2'd0, 5'd0, 2'd0);
    chk_out("rst", 1'b0, FWD_GRF, FWD_GRF);
`ifdef HAZARD_STAT_EN
    chk("rst.cnt", stall_cnt, 32'd0);
`endif
    reset = 1'b0;

    // 1: addu $1 (tnew 1) then beq rs=1 tuse 0: one stall, then M forwards.
    tick();
    do_reset();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd1, 2'd1);
    tick();
    set_d(5'd1, 2'd0, 5'd2, 2'd0, 5'd0, 2'd0);
    chk_out("t1.c0", 1'b1, FWD_GRF, FWD_GRF);
    tick();
    chk_out("t1.c1", 1'b0, FWD_M, FWD_GRF);
`ifdef HAZARD_STAT_EN
    chk("t1.cnt", stall_cnt, 32'd1);
`endif

    // 2: lw $2 (tnew 2) then addu rs=2 tuse 1: one stall, M non-ready gives GRF, W forwards later.
    do_reset();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd2, 2'd2);
    tick();
    set_d(5'd2, 2'd1, 5'd5, 2'd1, 5'd6, 2'd1);
    chk_out("t2.c0", 1'b1, FWD_GRF, FWD_GRF);
    tick();
    chk_out("t2.c1", 1'b0, FWD_GRF, FWD_GRF);
    tick();
    set_d(5'd2, 2'd1, 5'd0, TUSE_NONE, 5'd0, 2'd0);
    chk_out("t2.c2", 1'b0, FWD_W, FWD_GRF);

    // 3: jal (a3 31, tnew 0) then jr rs=31 tuse 0: E forwards; tnew 0 stays 0 into M.
    do_reset();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd31, 2'd0);
    tick();
    set_d(5'd31, 2'd0, 5'd0, TUSE_NONE, 5'd0, 2'd0);
    chk_out("t3.c0", 1'b0, FWD_E, FWD_GRF);
    tick();
    set_d(5'd0, TUSE_NONE, 5'd31, 2'd0, 5'd0, 2'd0);
    chk_out("t3.c1", 1'b0, FWD_GRF, FWD_M);

    // 4: write to $0 never creates a hazard.
    do_reset();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 2'd2);
    tick();
    set_d(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0);
    chk_out("t4", 1'b0, FWD_GRF, FWD_GRF);

    // 5: addu $3 twice, then sw rt=3 tuse 2: younger non-ready E masks ready M.
    do_reset();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd3, 2'd1);
    tick();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd3, 2'd1);
    tick();
    set_d(5'd0, 2'd1, 5'd3, 2'd2, 5'd0, 2'd0);
    chk_out("t5.c0", 1'b0, FWD_GRF, FWD_GRF);
    tick();
    set_d(5'd0, 2'd1, 5'd3, 2'd2, 5'd0, 2'd0);
    chk_out("t5.c1", 1'b0, FWD_GRF, FWD_M);
    tick();
    chk_out("t5.c2", 1'b0, FWD_GRF, FWD_W);

    // Stall on rs while rt forwards from M in the same cycle; Tuse none never stalls.
    do_reset();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd31, 2'd0);
    tick();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd7, 2'd2);
    tick();
    set_d(5'd7, 2'd0, 5'd31, 2'd0, 5'd0, 2'd0);
    chk_out("mix", 1'b1, FWD_GRF, FWD_M);
    set_d(5'd7, TUSE_NONE, 5'd0, TUSE_NONE, 5'd0, 2'd0);
    chk_out("tnone", 1'b0, FWD_GRF, FWD_GRF);

    // 6: lw $4 then a dependent read; reset mid-stall drops stall at once.
    do_reset();
    set_d(5'd0, TUSE_NONE, 5'd0, TUSE_NONE, 5'd4, 2'd2);
    tick();
    set_d(5'd4, 2'd0, 5'd4, 2'd1, 5'd0, 2'd0);
    chk_out("t6.pre", 1'b1, FWD_GRF, FWD_GRF);
    tick();
    chk_out("t6.hold", 1'b1, FWD_GRF, FWD_GRF);
    #2;
    reset = 1'b1;
    #1;
    chk_out("t6.rst", 1'b0, FWD_GRF, FWD_GRF);
`ifdef HAZARD_STAT_EN
    chk("t6.cnt", stall_cnt, 32'd0);
`endif
    reset = 1'b0;
    tick();
    chk_out("t6.post", 1'b0, FWD_GRF, FWD_GRF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
